ctrl_pipe: RTL and testbench

// - Consumer end of the main decoder's control interface. Latches the ID-stage control bundle
//   (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) plus rd/valid and carries it

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/ctrl_stage_reg.sv | 19 +
 rtl/ctrl_pipe.sv | 131 +++++++++++++
 tb/tb_ctrl_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the decoder-to-pipeline control interface.
// ctrl_t matches the 9-bit bundle driven by the main decoder, MSB first.
package ctrl_pkg;

  // The LSB of the bundle is reserved by the decoder and is only carried as far as EX.
  typedef struct packed {
    logic       alu_src;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] alu_op;
    logic       branch;
    logic       rsvd;
  } ctrl_t;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_RI   = 2'b10;
  localparam logic [1:0] ALUOP_LUI  = 2'b11;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline stage register: async active-low reset, hold when en=0,
// and a synchronous clear that loads an all-zero bubble.
module ctrl_stage_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= clr ? '0 : d;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoder control bundles through ID/EX, EX/MEM and MEM/WB, with load-use
// stalls, branch flushes and a saturating count of inserted bubbles.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  ctrl_t            id_ctrl_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  output logic             stall_o,
  output ctrl_t            ex_ctrl_o,
  output logic [REG_W-1:0] ex_rd_o,
  output logic             ex_valid_o,
  output logic [4:0]       mem_ctrl_o,
  output logic [REG_W-1:0] mem_rd_o,
  output logic             mem_valid_o,
  output logic             wb_memtoreg_o,
  output logic             wb_regwrite_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    ctrl_t            ctrl;
    logic [REG_W-1:0] rd;
    logic             valid;
  } ex_t;

  typedef struct packed {
    logic             memtoreg;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic [REG_W-1:0] rd;
    logic             valid;
  } mem_t;

  typedef struct packed {
    logic             memtoreg;
    logic             regwrite;
    logic [REG_W-1:0] rd;
    logic             valid;
  } wb_t;

  ex_t  ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d, wb_q;

  logic [1:0]       cnt_inc;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_q;

  // A freshly reset EX is a bubble, so stall_o is low throughout reset.
  assign stall_o = en_i & ~flush_i & id_valid_i & ex_q.valid & ex_q.ctrl.memread
                 & (ex_q.rd != '0) & ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i));

  always_comb begin
    ex_d = '0;
    if (id_valid_i) begin
      ex_d.ctrl  = id_ctrl_i;
      ex_d.rd    = id_rd_i;
      ex_d.valid = 1'b1;
    end
  end

  always_comb begin
    mem_d          = '0;
    mem_d.memtoreg = ex_q.ctrl.memtoreg;
    mem_d.regwrite = ex_q.ctrl.regwrite;
    mem_d.memread  = ex_q.ctrl.memread;
    mem_d.memwrite = ex_q.ctrl.memwrite;
    mem_d.branch   = ex_q.ctrl.branch;
    mem_d.rd       = ex_q.rd;
    mem_d.valid    = ex_q.valid;
  end

  always_comb begin
    wb_d          = '0;
    wb_d.memtoreg = mem_q.memtoreg;
    wb_d.regwrite = mem_q.regwrite;
    wb_d.rd       = mem_q.rd;
    wb_d.valid    = mem_q.valid;
  end

  ctrl_stage_reg #(.T(ex_t)) u_ex_reg (
    .clk(clk), .rst_n(rst_n), .en(en_i), .clr(flush_i | stall_o), .d(ex_d), .q(ex_q)
  );

  ctrl_stage_reg #(.T(mem_t)) u_mem_reg (
    .clk(clk), .rst_n(rst_n), .en(en_i), .clr(flush_i), .d(mem_d), .q(mem_q)
  );

  ctrl_stage_reg #(.T(wb_t)) u_wb_reg (
    .clk(clk), .rst_n(rst_n), .en(en_i), .clr(1'b0), .d(wb_d), .q(wb_q)
  );

  // A flush kills two slots, a stall one; the extra carry bit catches saturation.
  always_comb begin
    cnt_inc = 2'd0;
    if (flush_i)      cnt_inc = 2'd2;
    else if (stall_o) cnt_inc = 2'd1;
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(cnt_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  assign ex_ctrl_o     = ex_q.valid ? ex_q.ctrl : CTRL_BUBBLE;
  assign ex_rd_o       = ex_q.rd;
  assign ex_valid_o    = ex_q.valid;
  assign mem_ctrl_o    = mem_q.valid ? {mem_q.memtoreg, mem_q.regwrite, mem_q.memread,
                                        mem_q.memwrite, mem_q.branch} : 5'b0;
  assign mem_rd_o      = mem_q.rd;
  assign mem_valid_o   = mem_q.valid;
  assign wb_memtoreg_o = wb_q.valid & wb_q.memtoreg;
  assign wb_regwrite_o = wb_q.valid & wb_q.regwrite & (wb_q.rd != '0);
  assign wb_rd_o       = wb_q.rd;
  assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed and randomized checks of ctrl_pipe against a slot-shifting reference model;
// a second instance with a 2-bit counter exercises counter saturation.
module tb_ctrl_pipe;

  localparam logic [8:0] C_ADD = 9'b001001000;
  localparam logic [8:0] C_LW  = 9'b111100000;
  localparam logic [8:0] C_SW  = 9'b100010000;
  localparam logic [8:0] C_BR  = 9'b000000110;

  logic       clk = 1'b0;
  logic       rst_n, en, flush, id_valid;
  logic [8:0] id_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall, ex_valid, mem_valid, wb_memtoreg, wb_regwrite;
  logic [8:0]  ex_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd, mem_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_stall, s_ex_valid, s_mem_valid, s_wb_memtoreg, s_wb_regwrite;
  logic [8:0]  s_ex_ctrl;
  logic [4:0]  s_ex_rd, s_mem_rd, s_wb_rd, s_mem_ctrl;
  logic [1:0]  s_bubble_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] ctrl;
    logic [4:0] rd;
    logic       valid;
  } slot_t;

  // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  slot_t       pipe [3];
  int unsigned bubbles;

  always #5 clk = ~clk;

  ctrl_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .flush_i(flush), .id_valid_i(id_valid),
    .id_ctrl_i(id_ctrl), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .stall_o(stall), .ex_ctrl_o(ex_ctrl), .ex_rd_o(ex_rd), .ex_valid_o(ex_valid),
    .mem_ctrl_o(mem_ctrl), .mem_rd_o(mem_rd), .mem_valid_o(mem_valid),
    .wb_memtoreg_o(wb_memtoreg), .wb_regwrite_o(wb_regwrite), .wb_rd_o(wb_rd),
    .bubble_cnt_o(bubble_cnt)
  );

  ctrl_pipe #(.CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .en_i(en), .flush_i(flush), .id_valid_i(id_valid),
    .id_ctrl_i(id_ctrl), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .stall_o(s_stall), .ex_ctrl_o(s_ex_ctrl), .ex_rd_o(s_ex_rd), .ex_valid_o(s_ex_valid),
    .mem_ctrl_o(s_mem_ctrl), .mem_rd_o(s_mem_rd), .mem_valid_o(s_mem_valid),
    .wb_memtoreg_o(s_wb_memtoreg), .wb_regwrite_o(s_wb_regwrite), .wb_rd_o(s_wb_rd),
    .bubble_cnt_o(s_bubble_cnt)
  );

  function automatic slot_t bubble();
    slot_t b;
    b.ctrl = '0; b.rd = '0; b.valid = 1'b0;
    return b;
  endfunction

  function automatic logic exp_stall();
    return en && !flush && id_valid && pipe[0].valid && pipe[0].ctrl[5] &&
           pipe[0].rd != 0 && (pipe[0].rd == id_rs1 || pipe[0].rd == id_rs2);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    bubbles = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every output of both instances against the model's current view.
  task automatic checkPipeline();
    logic [8:0]  e_ex_ctrl;
    logic [4:0]  e_mem_ctrl;
    logic        e_wb_m, e_wb_r, e_st;
    logic [15:0] e_cnt;
    logic [1:0]  e_small;
    e_ex_ctrl  = pipe[0].valid ? pipe[0].ctrl : 9'b0;
    e_mem_ctrl = pipe[1].valid ? {pipe[1].ctrl[7], pipe[1].ctrl[6], pipe[1].ctrl[5],
                                  pipe[1].ctrl[4], pipe[1].ctrl[1]} : 5'b0;
    e_wb_m     = pipe[2].valid && pipe[2].ctrl[7];
    e_wb_r     = pipe[2].valid && pipe[2].ctrl[6] && pipe[2].rd != 0;
    e_st       = exp_stall();
    e_cnt      = (bubbles > 65535) ? 16'hFFFF : 16'(bubbles);
    e_small    = (bubbles > 3) ? 2'd3 : 2'(bubbles);
    checkOutput("stall", 64'(stall), 64'(e_st));
    checkOutput("ex_ctrl", 64'(ex_ctrl), 64'(e_ex_ctrl));
    checkOutput("ex_rd", 64'(ex_rd), 64'(pipe[0].rd));
    checkOutput("ex_valid", 64'(ex_valid), 64'(pipe[0].valid));
    checkOutput("mem_ctrl", 64'(mem_ctrl), 64'(e_mem_ctrl));
    checkOutput("mem_rd", 64'(mem_rd), 64'(pipe[1].rd));
    checkOutput("mem_valid", 64'(mem_valid), 64'(pipe[1].valid));
    checkOutput("wb_memtoreg", 64'(wb_memtoreg), 64'(e_wb_m));
    checkOutput("wb_regwrite", 64'(wb_regwrite), 64'(e_wb_r));
    checkOutput("wb_rd", 64'(wb_rd), 64'(pipe[2].rd));
    checkOutput("bubble_cnt", 64'(bubble_cnt), 64'(e_cnt));
    checkOutput("small_cnt", 64'(s_bubble_cnt), 64'(e_small));
    checkOutput("small_bus",
      64'({s_stall, s_ex_ctrl, s_ex_rd, s_ex_valid, s_mem_ctrl, s_mem_rd, s_mem_valid,
           s_wb_memtoreg, s_wb_regwrite, s_wb_rd}),
      64'({e_st, e_ex_ctrl, pipe[0].rd, pipe[0].valid, e_mem_ctrl, pipe[1].rd, pipe[1].valid,
           e_wb_m, e_wb_r, pipe[2].rd}));
  endtask

  task automatic applyStimulus(input logic e, input logic f, input logic v,
                               input logic [8:0] c, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] rd);
    @(negedge clk);
    en = e; flush = f; id_valid = v; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    #1;
    checkPipeline();
  endtask

  // Advances the model by one clock using the rules, then lets the DUT take the edge.
  task automatic tick();
    slot_t in_slot;
    if (rst_n && en) begin
      if (flush) begin
        pipe[2] = pipe[1]; pipe[1] = bubble(); pipe[0] = bubble();
        bubbles += 2;
      end else if (exp_stall()) begin
        pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = bubble();
        bubbles += 1;
      end else begin
        in_slot = bubble();
        if (id_valid) begin
          in_slot.ctrl = id_ctrl; in_slot.rd = id_rd; in_slot.valid = 1'b1;
        end
        pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = in_slot;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 9'b0, 5'd0, 5'd0, 5'd0);
    tick();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkPipeline();
    checkOutput("rst_async_cnt", 64'(bubble_cnt), 64'd0);
    en = 1'b0; flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       hold;
    logic       r_v;
    logic [8:0] r_c;
    logic [4:0] r_rs1, r_rs2, r_rd;

    rst_n = 1'b0; en = 1'b1; flush = 1'b0; id_valid = 1'b1;
    id_ctrl = C_LW; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd1;
    modelReset();
    @(negedge clk);
    #1;
    checkPipeline();
    en = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add x3 walks EX, MEM, WB.
    applyStimulus(1'b1, 1'b0, 1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
    tick(); #1;
    checkOutput("add_ex_ctrl", 64'(ex_ctrl), 64'(C_ADD));
    idle(); #1;
    checkOutput("add_mem_ctrl", 64'(mem_ctrl), 64'(5'b01000));
    idle(); #1;
    checkOutput("add_wb_regwrite", 64'(wb_regwrite), 64'd1);
    checkOutput("add_wb_rd", 64'(wb_rd), 64'd3);

    // lw x5; add x6,x5,x1 stalls exactly once.
    applyStimulus(1'b1, 1'b0, 1'b1, C_LW, 5'd1, 5'd0, 5'd5);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, C_ADD, 5'd5, 5'd1, 5'd6);
    checkOutput("lu_stall", 64'(stall), 64'd1);
    tick(); #1;
    checkOutput("lu_ex_bubble", 64'(ex_valid), 64'd0);
    checkOutput("lu_cnt", 64'(bubble_cnt), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, C_ADD, 5'd5, 5'd1, 5'd6);
    checkOutput("lu_stall_once", 64'(stall), 64'd0);
    tick();
    idle();
    idle(); #1;
    checkOutput("lu_add_wb_rd", 64'(wb_rd), 64'd6);

    // lw x0 followed by a use of x0; add with rd=0 must not write.
    applyStimulus(1'b1, 1'b0, 1'b1, C_LW, 5'd2, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, C_ADD, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_no_stall", 64'(stall), 64'd0);
    tick();
    idle();
    idle(); #1;
    checkOutput("rd0_no_write", 64'(wb_regwrite), 64'd0);

    // Branch resolves in MEM and flushes ID and EX.
    applyStimulus(1'b1, 1'b0, 1'b1, C_BR, 5'd1, 5'd2, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, C_ADD, 5'd1, 5'd2, 5'd7);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, C_ADD, 5'd1, 5'd2, 5'd8);
    tick(); #1;
    checkOutput("flush_ex", 64'(ex_valid), 64'd0);
    checkOutput("flush_mem", 64'(mem_valid), 64'd0);
    checkOutput("flush_wb_regwrite", 64'(wb_regwrite), 64'd0);
    checkOutput("flush_cnt", 64'(bubble_cnt), 64'd3);

    // Load-use hazard and flush together: flush wins.
    applyStimulus(1'b1, 1'b0, 1'b1, C_LW, 5'd1, 5'd2, 5'd7);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, C_ADD, 5'd7, 5'd0, 5'd9);
    checkOutput("flush_beats_stall", 64'(stall), 64'd0);
    tick(); #1;
    checkOutput("cnt_after_5", 64'(bubble_cnt), 64'd5);
    checkOutput("small_saturated", 64'(s_bubble_cnt), 64'd3);

    // Freeze for three cycles with a pending flush and a would-be hazard.
    applyStimulus(1'b1, 1'b0, 1'b1, C_LW, 5'd1, 5'd2, 5'd10);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, C_ADD, 5'd10, 5'd10, 5'd11);
      checkOutput("freeze_no_stall", 64'(stall), 64'd0);
      tick();
    end
    #1;
    checkOutput("freeze_cnt", 64'(bubble_cnt), 64'd5);
    checkOutput("freeze_ex_rd", 64'(ex_rd), 64'd10);

    // Reset in the middle of a busy pipeline.
    applyStimulus(1'b1, 1'b0, 1'b1, C_SW, 5'd3, 5'd4, 5'd12);
    tick();
    doReset();

    // Randomized traffic over a small register range to provoke hazards.
    hold = 1'b0;
    r_v = 1'b0; r_c = '0; r_rs1 = '0; r_rs2 = '0; r_rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      if (!hold) begin
        r_v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 4))
          0: r_c = C_ADD;
          1: r_c = C_LW;
          2: r_c = C_SW;
          3: r_c = C_BR;
          default: r_c = 9'($urandom);
        endcase
        r_rs1 = 5'($urandom_range(0, 3));
        r_rs2 = 5'($urandom_range(0, 3));
        r_rd  = 5'($urandom_range(0, 3));
      end
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, r_v, r_c,
                    r_rs1, r_rs2, r_rd);
      hold = exp_stall();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
